// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit: FSM state type,
// iteration-count helpers and parameter legality test.
package sqrt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    // Number of clock edges needed to resolve all WIDTH/2 root bits.
    function automatic int calc_n(input int width, input int steps);
        int s;
        s = (steps < 1) ? 1 : steps;
        return width / (2 * s);
    endfunction

    function automatic int cnt_width(input int width, input int steps);
        int n;
        n = calc_n(width, steps);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int width, input int steps);
        return (width >= 2) && ((width % 2) == 0) && (steps >= 1) &&
               (((width / 2) % steps) == 0);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit iteration of the square root: brings in the next
// radicand bit pair and resolves one root bit.
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH/2+1:0] r_i,
    input  logic [WIDTH/2-1:0] q_i,
    input  logic [1:0]         pair_i,
    output logic [WIDTH/2+1:0] r_o,
    output logic [WIDTH/2-1:0] q_o
);

    localparam int QW = WIDTH / 2;
    localparam int RW = QW + 2;

    logic [RW-1:0] r_sh_s;
    logic [RW-1:0] t_s;
    logic          ge_s;

    assign r_sh_s = (r_i << 2) | {{(RW-2){1'b0}}, pair_i};
    assign t_s    = {q_i, 2'b01};
    assign ge_s   = (r_sh_s >= t_s);

    // Subtract trial value when it fits and shift the new root bit in.
    always_comb begin
        r_o = r_sh_s;
        q_o = q_i << 1;
        if (ge_s) begin
            r_o = r_sh_s - t_s;
            q_o = (q_i << 1) | {{(QW-1){1'b0}}, 1'b1};
        end else begin
            r_o = r_sh_s;
            q_o = q_i << 1;
        end
    end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root with start/busy handshake, done pulse,
// remainder output and synchronous abort.
module sqrt_iter
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEPS = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   x_bi,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH/2-1:0] y_bo,
    output logic [WIDTH/2:0]   rem_bo
);

    localparam int N  = calc_n(WIDTH, STEPS);
    localparam int CW = cnt_width(WIDTH, STEPS);
    localparam int QW = WIDTH / 2;
    localparam int RW = QW + 2;

    if (!params_ok(WIDTH, STEPS)) begin : g_bad_params
        $error("sqrt_iter: WIDTH must be even and >= 2, STEPS must divide WIDTH/2");
    end

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0] x_q,    x_d;
    logic [RW-1:0]   r_q,     r_d;
    logic [QW-1:0]   q_q,     q_d;
    logic [QW-1:0]   y_q,     y_d;
    logic [QW:0]     rem_q,   rem_d;
    logic            done_q,  done_d;

    logic [RW-1:0]   r_c [STEPS+1];
    logic [QW-1:0]   q_c [STEPS+1];

    assign r_c[0] = r_q;
    assign q_c[0] = q_q;

    // The radicand register is consumed MSB-first, so step i reads pair i.
    for (genvar i = 0; i < STEPS; i++) begin : g_step
        sqrt_step #(.WIDTH(WIDTH)) u_step (
            .r_i    (r_c[i]),
            .q_i    (q_c[i]),
            .pair_i (x_q[WIDTH-1-2*i -: 2]),
            .r_o    (r_c[i+1]),
            .q_o    (q_c[i+1])
        );
    end

    // Next-state logic for FSM, datapath and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        r_d     = r_q;
        q_d     = q_q;
        y_d     = y_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CALC;
                    x_d     = x_bi;
                    r_d     = {RW{1'b0}};
                    q_d     = {QW{1'b0}};
                    cnt_d   = CW'(N - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // Abort wins even on the final edge: no result, no pulse.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == {CW{1'b0}}) begin
                    state_d = IDLE;
                    r_d     = r_c[STEPS];
                    q_d     = q_c[STEPS];
                    y_d     = q_c[STEPS];
                    rem_d   = r_c[STEPS][QW:0];
                    done_d  = 1'b1;
                end else begin
                    r_d   = r_c[STEPS];
                    q_d   = q_c[STEPS];
                    x_d   = x_q << (2 * STEPS);
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            x_q     <= {WIDTH{1'b0}};
            r_q     <= {RW{1'b0}};
            q_q     <= {QW{1'b0}};
            y_q     <= {QW{1'b0}};
            rem_q   <= {(QW+1){1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            r_q     <= r_d;
            q_q     <= q_d;
            y_q     <= y_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = done_q;
    assign y_bo   = y_q;
    assign rem_bo = rem_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: an 8-bit/1-step and a 16-bit/2-step instance.
module tb_sqrt_iter;

    logic       clk;
    logic       rst_n;
    logic       s8, a8, s16, a16;
    logic [7:0] x8;
    logic [15:0] x16;
    logic       busy8, done8, busy16, done16;
    logic [3:0] y8;
    logic [4:0] rem8;
    logic [7:0] y16;
    logic [8:0] rem16;

    int checks = 0;
    int errors = 0;

    sqrt_iter #(.WIDTH(8), .STEPS(1)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s8), .abort_i(a8), .x_bi(x8),
        .busy_o(busy8), .done_o(done8), .y_bo(y8), .rem_bo(rem8)
    );

    sqrt_iter #(.WIDTH(16), .STEPS(2)) u16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s16), .abort_i(a16), .x_bi(x16),
        .busy_o(busy16), .done_o(done16), .y_bo(y16), .rem_bo(rem16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start one 8-bit operation and wait (bounded) for done; lat = -1 on timeout.
    task automatic run8(input logic [7:0] x, output logic [3:0] y,
                        output logic [4:0] rem, output int lat);
        @(negedge clk); s8 = 1'b1; x8 = x;
        @(negedge clk); s8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin lat = i; break; end
        end
        y = y8; rem = rem8;
    endtask

    task automatic run16(input logic [15:0] x, output logic [7:0] y,
                         output logic [8:0] rem, output int lat);
        @(negedge clk); s16 = 1'b1; x16 = x;
        @(negedge clk); s16 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done16) begin lat = i; break; end
        end
        y = y16; rem = rem16;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy8, done8, y8, rem8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b y=%0d rem=%0d, want all 0", busy8, done8, y8, rem8);
        end
        checks++;
        if ({busy16, done16, y16, rem16} !== 19'd0) begin
            errors++;
            $display("FAIL reset16: got busy=%b done=%b y=%0d rem=%0d, want all 0", busy16, done16, y16, rem16);
        end
    endtask

    task automatic test_basic;
        int lat;
        @(negedge clk); s8 = 1'b1; x8 = 8'd9;
        @(negedge clk); s8 = 1'b0;
        lat = -1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle %0d: got busy=%b done=%b, want 1 0", i, busy8, done8);
            end
            @(negedge clk);
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b after 4 cycles, want 1 0", done8, busy8);
        end
        checks++;
        if (y8 !== 4'd3 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL basic_x9: got %0d,%0d want 3,0", y8, rem8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: done still %b one cycle later, want 0", done8);
        end
    endtask

    task automatic test_sweep;
        logic [3:0] y;
        logic [4:0] rem;
        int lat;
        for (int x = 0; x < 256; x++) begin
            run8(8'(x), y, rem, lat);
            checks++;
            if (lat != 4 || (int'(y) * int'(y) + int'(rem)) != x || int'(rem) > 2 * int'(y)) begin
                errors++;
                $display("FAIL sweep x=%0d: got y=%0d rem=%0d lat=%0d, want y*y+rem=x rem<=2y lat=4", x, y, rem, lat);
            end
        end
        run8(8'd0, y, rem, lat);
        checks++;
        if (y !== 4'd0 || rem !== 5'd0) begin
            errors++;
            $display("FAIL corner_x0: got %0d,%0d want 0,0", y, rem);
        end
        run8(8'd255, y, rem, lat);
        checks++;
        if (y !== 4'd15 || rem !== 5'd30) begin
            errors++;
            $display("FAIL corner_x255: got %0d,%0d want 15,30", y, rem);
        end
    endtask

    task automatic test_wide;
        logic [7:0] y;
        logic [8:0] rem;
        int lat;
        run16(16'd65535, y, rem, lat);
        checks++;
        if (y !== 8'd255 || rem !== 9'd510 || lat != 4) begin
            errors++;
            $display("FAIL wide_65535: got %0d,%0d lat=%0d want 255,510 lat=4", y, rem, lat);
        end
        run16(16'd40000, y, rem, lat);
        checks++;
        if (y !== 8'd200 || rem !== 9'd0 || lat != 4) begin
            errors++;
            $display("FAIL wide_40000: got %0d,%0d lat=%0d want 200,0 lat=4", y, rem, lat);
        end
        run16(16'd2, y, rem, lat);
        checks++;
        if (y !== 8'd1 || rem !== 9'd1) begin
            errors++;
            $display("FAIL wide_2: got %0d,%0d want 1,1", y, rem);
        end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        int lat = -1;
        @(negedge clk); s8 = 1'b1; x8 = 8'd100;
        @(negedge clk); s8 = 1'b0;
        @(negedge clk);
        @(negedge clk); s8 = 1'b1; x8 = 8'd49;
        @(negedge clk); s8 = 1'b0;
        if (done8) dones++;
        @(negedge clk);
        if (done8) dones++;
        checks++;
        if (done8 !== 1'b1 || y8 !== 4'd10 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL ignore_start: got done=%b %0d,%0d want 1 10,0", done8, y8, rem8);
        end
        s8 = 1'b1; x8 = 8'd49;
        @(negedge clk); s8 = 1'b0;
        if (done8) dones++;
        checks++;
        if (dones != 1 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got dones=%0d busy=%b want 1 1", dones, busy8);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin lat = i; break; end
        end
        checks++;
        if (lat != 4 || y8 !== 4'd7 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL b2b_result: got %0d,%0d lat=%0d want 7,0 lat=4", y8, rem8, lat);
        end
    endtask

    task automatic test_abort;
        logic [3:0] y;
        logic [4:0] rem;
        int lat;
        int dones = 0;
        run8(8'd9, y, rem, lat);
        @(negedge clk); s8 = 1'b1; x8 = 8'd200;
        @(negedge clk); s8 = 1'b0;
        @(negedge clk); a8 = 1'b1;
        @(negedge clk); a8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || y8 !== 4'd3 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL abort_mid: got busy=%b done=%b %0d,%0d want 0 0 3,0", busy8, done8, y8, rem8);
        end
        repeat (6) begin
            @(negedge clk);
            if (done8) dones++;
        end
        checks++;
        if (dones != 0 || y8 !== 4'd3) begin
            errors++;
            $display("FAIL abort_quiet: got dones=%0d y=%0d want 0 3", dones, y8);
        end
        @(negedge clk); s8 = 1'b1; x8 = 8'd200;
        @(negedge clk); s8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); a8 = 1'b1;
        @(negedge clk); a8 = 1'b0;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 4'd3 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL abort_final: got done=%b busy=%b %0d,%0d want 0 0 3,0", done8, busy8, y8, rem8);
        end
        @(negedge clk); s8 = 1'b1; a8 = 1'b1; x8 = 8'd16;
        @(negedge clk); s8 = 1'b0; a8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_start: got busy=%b want 1", busy8);
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin lat = i; break; end
        end
        checks++;
        if (lat != 4 || y8 !== 4'd4 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL abort_idle_result: got %0d,%0d lat=%0d want 4,0 lat=4", y8, rem8, lat);
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] y;
        logic [4:0] rem;
        int lat;
        @(negedge clk); s8 = 1'b1; x8 = 8'd200;
        @(negedge clk); s8 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || y8 !== 4'd0 || rem8 !== 5'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b %0d,%0d want 0 0 0,0", busy8, done8, y8, rem8);
        end
        @(negedge clk); rst_n = 1'b1;
        run8(8'd81, y, rem, lat);
        checks++;
        if (y !== 4'd9 || rem !== 5'd0 || lat != 4) begin
            errors++;
            $display("FAIL after_reset_x81: got %0d,%0d lat=%0d want 9,0 lat=4", y, rem, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        s8 = 1'b0; a8 = 1'b0; x8 = 8'd0;
        s16 = 1'b0; a16 = 1'b0; x16 = 16'd0;
        #2;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_basic();
        test_sweep();
        test_wide();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
